// File: rtl/mips_inst_encoder.sv
// Program loader: encodes mnemonic-level requests into MIPS words, buffers them
// in a small FIFO and streams them into instruction memory at consecutive addresses.
module mips_inst_encoder #(
  parameter int unsigned   DEPTH     = 4,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ovf,
  output logic [15:0]   word_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]   fifo_q [DEPTH];
  logic [PW:0]   rd_q, wr_q;
  logic          empty, full;
  logic [AW-1:0] wp_q;
  logic [AW:0]   wp_inc;
  logic          mem_we_q, done_q, err_q, ovf_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [15:0]   cnt_q;
  logic [31:0]   enc_word;
  logic          legal, accept, push, pop;

  assign empty    = (rd_q == wr_q);
  assign full     = (rd_q[PW] != wr_q[PW]) && (rd_q[PW-1:0] == wr_q[PW-1:0]);
  assign busy     = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign in_ready = (state_q == S_LOAD) && !full;
  assign accept   = in_valid && in_ready;
  // start discards the buffer, so neither a push nor a pop may land on that edge
  assign push     = accept && legal && !start;
  assign pop      = busy && !empty && mem_ready && !start;
  assign wp_inc   = {1'b0, wp_q} + (AW+1)'(4);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign word_cnt  = cnt_q;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (op_sel)
      4'd0:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
      4'd1:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
      4'd2:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      4'd3:  enc_word = {6'b000000, rs, 15'b0, 6'b001000};
      4'd4:  enc_word = {6'b001000, rs, rt, imm};
      4'd5:  enc_word = {6'b001010, rs, rt, imm};
      4'd6:  enc_word = {6'b100011, rs, rt, imm};
      4'd7:  enc_word = {6'b101011, rs, rt, imm};
      4'd8:  enc_word = {6'b000010, target};
      4'd9:  enc_word = {6'b000011, target};
      4'd10: enc_word = {6'b000100, rs, rt, imm};
      4'd11: enc_word = {6'b000101, rs, rt, imm};
      4'd12: enc_word = {6'b110011, 26'b0};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (finish) state_d = S_FLUSH;
        S_FLUSH: if (empty)  state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[PW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= '0;
      wr_q        <= '0;
      wp_q        <= BASE_ADDR;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (start) begin
      rd_q     <= '0;
      wr_q     <= '0;
      wp_q     <= BASE_ADDR;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (accept && !legal) err_q <= 1'b1;
      if (state_q == S_FLUSH && empty) done_q <= 1'b1;
      mem_we_q <= pop;
      if (pop) begin
        rd_q        <= rd_q + (PW+1)'(1);
        mem_addr_q  <= wp_q;
        mem_wdata_q <= fifo_q[rd_q[PW-1:0]];
        wp_q        <= wp_inc[AW-1:0];
        if (wp_inc[AW]) ovf_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
- Encodes mnemonic-level requests (op select plus register and immediate fields) into 32-bit MIPS instruction words using the same opcode/funct map the control unit decodes.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory.
- Serves as the program loader on the writer side of the instruction memory that the fetch/decode path reads.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2)
- AW, 32, memory byte-address width
- BASE_ADDR, 0, first write address after start

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; begin a new load session
- finish  input  1  pulse; no more requests, drain and complete
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- op_sel  input  4  0 ADD, 1 SUB, 2 SLT, 3 JR, 4 ADDI, 5 SLTI, 6 LW, 7 SW, 8 J, 9 JAL, 10 BEQ, 11 BNE, 12 NOP; 13-15 illegal
- rs, rt, rd  input  5 each  register fields
- imm  input  16  I-type immediate
- target  input  26  J-type target
- mem_ready  input  1  memory can take a write this cycle
- mem_we  output  1  one-cycle write strobe
- mem_addr  output  AW  byte address
- mem_wdata  output  32  encoded instruction
- busy  output  1  state is LOAD or FLUSH
- done  output  1  high in DONE
- err  output  1  sticky illegal-op flag
- ovf  output  1  sticky address wrap flag
- word_cnt  output  16  words written this session

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, write pointer = BASE_ADDR.
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> FLUSH on finish.
  - FLUSH -> DONE when the FIFO is empty and no write is pending.
  - DONE -> LOAD on start.
- start in any state:
  - Discards FIFO contents.
  - Write pointer = BASE_ADDR.
  - Clears err, ovf, word_cnt and done.
  - Enters LOAD.
  - start has priority over finish in the same cycle.
- in_ready = (state == LOAD) && !full. It is independent of mem_ready and of a same-cycle pop.
- Encoding is combinational at acceptance; the encoded word is pushed into the FIFO:
  - R-type (ADD/SUB/SLT): {6'b000000, rs, rt, rd, 5'b0, funct}; funct is 100000 for ADD, 100010 for SUB, 101010 for SLT.
  - JR: {6'b000000, rs, 15'b0, 6'b001000}.
  - I-type: {opcode, rs, rt, imm}; opcodes are ADDI 001000, SLTI 001010, LW 100011, SW 101011, BEQ 000100, BNE 000101.
  - J/JAL: {opcode, target}; opcodes are J 000010, JAL 000011.
  - NOP: {6'b110011, 26'b0}.
- Illegal op_sel:
  - The handshake completes but nothing is pushed.
  - err is set on the next edge and stays set until start or rst.
- Drain, evaluated at each edge in LOAD or FLUSH:
  - If the FIFO is non-empty and mem_ready is high: mem_we <= 1, mem_wdata <= head, mem_addr <= write pointer; pop; write pointer += 4; word_cnt += 1.
  - Otherwise mem_we <= 0. mem_addr and mem_wdata hold their previous values.
  - mem_we is never asserted in IDLE or DONE.
- Latency:
  - A request accepted at edge k into an empty FIFO with mem_ready high appears on mem_* after edge k+1.
  - Sustained throughput is 1 word/clk.
- Simultaneous push and pop:
  - Allowed when the FIFO is not full.
  - Occupancy is unchanged and order is preserved (FIFO order equals acceptance order).
- Write pointer wrap: on increment from (2^AW − 4), the pointer wraps modulo 2^AW and ovf is set (sticky).
- word_cnt saturates at 0xFFFF.
- Completion: done rises on the edge where FLUSH exits with the FIFO empty, and holds until start or rst.
- finish while IDLE or DONE is ignored.
- rst asserted mid-session: everything returns to reset values immediately; in-flight words are lost.

Test Plan:
- Reset, start, ADD rs=1 rt=2 rd=3, finish, mem_ready=1 -> one write: addr 0x0, data 0x00221820; done=1; word_cnt=1.
- Back-to-back ADDI r2,r0,5; LW r4,8(r2); BEQ r2,r4,-1; J 0x100; NOP with mem_ready=1:
  - Data 0x20020005, 0x8C440008, 0x1044FFFF, 0x08000100, 0xCC000000.
  - Addresses 0,4,8,12,16, on consecutive cycles.
- mem_ready=0 while pushing -> in_ready falls after DEPTH accepts; then mem_ready=1 -> all DEPTH words written in order, 1 per clk, and in_ready rises.
- op_sel=14 between two SUB requests -> err=1; exactly 2 writes at 0x0 and 0x4; the SUB words have funct 0x22.
- AW=4, BASE_ADDR=0xC, two JR rs=31 -> writes at 0xC then 0x0; ovf=1; data 0x03E00008.
- start mid-FLUSH with 3 words buffered and mem_ready=0 -> no writes occur; FIFO is empty; next write is at BASE_ADDR. rst mid-LOAD -> all outputs are 0 asynchronously.
